// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: load Funct3 encodings, writeback buffer
// occupancy states and the default datapath width.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load formatter: selects the addressed byte/half of a raw
// memory word and sign- or zero-extends it according to Funct3.
module load_formatter
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] RawData,
    input  logic [1:0]        AddrLsb,
    input  logic [2:0]        Funct3,
    input  logic              MemtoReg,
    output logic [DATA_W-1:0] FormattedData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = RawData[7:0];
        unique case (AddrLsb)
            2'd0: w_byte = RawData[7:0];
            2'd1: w_byte = RawData[15:8];
            2'd2: w_byte = RawData[23:16];
            2'd3: w_byte = RawData[31:24];
            default: w_byte = RawData[7:0];
        endcase
    end

    // Halfword select ignores AddrLsb[0]; misaligned halves are not split.
    assign w_half = AddrLsb[1] ? RawData[31:16] : RawData[15:0];

    always_comb begin
        FormattedData = RawData;
        if (MemtoReg) begin
            case (Funct3)
                F3_LB:   FormattedData = {{(DATA_W-8){w_byte[7]}}, w_byte};
                F3_LBU:  FormattedData = {{(DATA_W-8){1'b0}}, w_byte};
                F3_LH:   FormattedData = {{(DATA_W-16){w_half[15]}}, w_half};
                F3_LHU:  FormattedData = {{(DATA_W-16){1'b0}}, w_half};
                F3_LW:   FormattedData = RawData;
                default: FormattedData = RawData;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage_buffer.sv
// MEM/WB stage register with valid/ready handshake, optional one-entry skid
// buffer, and load formatting at capture so write data is a pure register.
module wb_stage_buffer
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_W    = 5,
    parameter int SKID_EN = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FlushW,
    input  logic              InValidM,
    output logic              InReadyM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ReadDataM,
    input  logic [DATA_W-1:0] ComputeResultM,
    input  logic [1:0]        AddrLsbM,
    input  logic [RD_W-1:0]   rdM,
    input  logic [2:0]        Funct3M,
    output logic              OutValidW,
    input  logic              OutReadyW,
    output logic              RegWriteW,
    output logic [RD_W-1:0]   rdW,
    output logic [DATA_W-1:0] WriteDataW,
    output logic [2:0]        Funct3W
);

    wb_state_e         r_state;
    logic              r_in_ready;

    logic              r_head_rw;
    logic [RD_W-1:0]   r_head_rd;
    logic [DATA_W-1:0] r_head_data;
    logic [2:0]        r_head_f3;

    logic              r_skid_rw;
    logic [RD_W-1:0]   r_skid_rd;
    logic [DATA_W-1:0] r_skid_data;
    logic [2:0]        r_skid_f3;

    logic [DATA_W-1:0] w_fmt;
    logic [DATA_W-1:0] w_in_data;
    logic              w_accept;
    logic              w_pop;

    load_formatter #(
        .DATA_W (DATA_W)
    ) u_fmt (
        .RawData       (ReadDataM),
        .AddrLsb       (AddrLsbM),
        .Funct3        (Funct3M),
        .MemtoReg      (MemtoRegM),
        .FormattedData (w_fmt)
    );

    assign w_in_data = MemtoRegM ? w_fmt : ComputeResultM;

    assign OutValidW = (r_state != ST_EMPTY);
    // Skid mode breaks the OutReadyW -> InReadyM path with a registered ready.
    assign InReadyM  = (SKID_EN != 0) ? r_in_ready : (!OutValidW || OutReadyW);
    assign w_accept  = InValidM && InReadyM;
    assign w_pop     = OutValidW && OutReadyW;

    assign RegWriteW  = w_pop && r_head_rw && (r_head_rd != '0);
    assign rdW        = r_head_rd;
    assign WriteDataW = r_head_data;
    assign Funct3W    = r_head_f3;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_head_rw   <= 1'b0;
            r_head_rd   <= '0;
            r_head_data <= '0;
            r_head_f3   <= '0;
        end else if (FlushW) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_rw   <= RegWriteM;
                        r_head_rd   <= rdM;
                        r_head_data <= w_in_data;
                        r_head_f3   <= Funct3M;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head_rw   <= RegWriteM;
                        r_head_rd   <= rdM;
                        r_head_data <= w_in_data;
                        r_head_f3   <= Funct3M;
                    end else if (w_accept && (SKID_EN != 0)) begin
                        r_skid_rw   <= RegWriteM;
                        r_skid_rd   <= rdM;
                        r_skid_data <= w_in_data;
                        r_skid_f3   <= Funct3M;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_head_rw   <= r_skid_rw;
                        r_head_rd   <= r_skid_rd;
                        r_head_data <= r_skid_data;
                        r_head_f3   <= r_skid_f3;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Directed bench for wb_stage_buffer: scoreboard of formatted beats plus
// direct checks of handshake, hold, flush and reset behaviour.
module tb_wb_stage_buffer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FlushW = 1'b0;
    logic        InValidM = 1'b0;
    logic        InValid0 = 1'b0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [31:0] ReadDataM = '0;
    logic [31:0] ComputeResultM = '0;
    logic [1:0]  AddrLsbM = '0;
    logic [4:0]  rdM = '0;
    logic [2:0]  Funct3M = '0;
    logic        OutReadyW = 1'b0;

    logic        InReadyM, OutValidW, RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] WriteDataW;
    logic [2:0]  Funct3W;

    logic        InReady0, OutValid0, RegWrite0;
    logic [4:0]  rd0;
    logic [31:0] WriteData0;
    logic [2:0]  Funct30;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        we;
    } beat_t;

    beat_t sb[$];

    always #5 CLK = ~CLK;

    wb_stage_buffer #(.DATA_W(32), .RD_W(5), .SKID_EN(1)) dut (
        .CLK(CLK), .RESET(RESET), .FlushW(FlushW),
        .InValidM(InValidM), .InReadyM(InReadyM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ReadDataM(ReadDataM), .ComputeResultM(ComputeResultM),
        .AddrLsbM(AddrLsbM), .rdM(rdM), .Funct3M(Funct3M),
        .OutValidW(OutValidW), .OutReadyW(OutReadyW),
        .RegWriteW(RegWriteW), .rdW(rdW),
        .WriteDataW(WriteDataW), .Funct3W(Funct3W)
    );

    wb_stage_buffer #(.DATA_W(32), .RD_W(5), .SKID_EN(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .FlushW(FlushW),
        .InValidM(InValid0), .InReadyM(InReady0),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ReadDataM(ReadDataM), .ComputeResultM(ComputeResultM),
        .AddrLsbM(AddrLsbM), .rdM(rdM), .Funct3M(Funct3M),
        .OutValidW(OutValid0), .OutReadyW(OutReadyW),
        .RegWriteW(RegWrite0), .rdW(rd0),
        .WriteDataW(WriteData0), .Funct3W(Funct30)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic m2r, input logic [2:0] f3,
                                        input logic [1:0] lsb, input logic [31:0] raw,
                                        input logic [31:0] cres);
        logic [31:0] b, h;
        b = raw >> (8 * lsb);
        h = raw >> (16 * lsb[1]);
        if (!m2r) return cres;
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return raw;
        endcase
    endfunction

    // Monitor: observes edge outcomes half a cycle ahead of the edge.
    always @(negedge CLK) begin
        beat_t e;
        if (RESET || FlushW) begin
            sb.delete();
        end else begin
            if (OutValidW && OutReadyW) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rd", {27'd0, rdW}, {27'd0, e.rd});
                    chk("sb_data", WriteDataW, e.data);
                    chk("sb_f3", {29'd0, Funct3W}, {29'd0, e.f3});
                    chk("sb_we", {31'd0, RegWriteW}, {31'd0, e.we});
                end
            end else begin
                chk("we_idle", {31'd0, RegWriteW}, 32'd0);
            end
            if (InValidM && InReadyM) begin
                e.rd = rdM;
                e.data = fmt(MemtoRegM, Funct3M, AddrLsbM, ReadDataM, ComputeResultM);
                e.f3 = Funct3M;
                e.we = RegWriteM && (rdM != 5'd0);
                sb.push_back(e);
            end
        end
    end

    task automatic beat(input logic v, input logic rw, input logic m2r,
                        input logic [31:0] rdata, input logic [31:0] cres,
                        input logic [1:0] lsb, input logic [4:0] rd, input logic [2:0] f3);
        InValidM = v; RegWriteM = rw; MemtoRegM = m2r; ReadDataM = rdata;
        ComputeResultM = cres; AddrLsbM = lsb; rdM = rd; Funct3M = f3;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        RESET = 1'b0;
        chk("rst_valid", {31'd0, OutValidW}, 32'd0);
        chk("rst_we", {31'd0, RegWriteW}, 32'd0);
        chk("rst_rd", {27'd0, rdW}, 32'd0);
        chk("rst_data", WriteDataW, 32'd0);
        chk("rst_f3", {29'd0, Funct3W}, 32'd0);
        chk("rst_ready", {31'd0, InReadyM}, 32'd1);

        // Load formatting with the port always granted.
        OutReadyW = 1'b1;
        beat(1, 1, 1, 32'h1280_3456, 32'h0, 2'd2, 5'd3, 3'b000);
        step();
        chk("lb_valid", {31'd0, OutValidW}, 32'd1);
        chk("lb_data", WriteDataW, 32'hFFFF_FF80);
        beat(1, 1, 1, 32'h1280_3456, 32'h0, 2'd2, 5'd3, 3'b100);
        step();
        chk("lbu_data", WriteDataW, 32'h0000_0080);
        beat(1, 1, 1, 32'hBEEF_1234, 32'h0, 2'd3, 5'd4, 3'b101);
        step();
        chk("lhu_data", WriteDataW, 32'h0000_BEEF);
        beat(1, 1, 1, 32'hBEEF_1234, 32'h0, 2'd1, 5'd4, 3'b001);
        step();
        chk("lh_data", WriteDataW, 32'h0000_1234);

        // Writes to x0 are popped but never enabled.
        beat(1, 1, 0, 32'hDEAD_BEEF, 32'h55, 2'd0, 5'd0, 3'b010);
        step();
        chk("x0_we", {31'd0, RegWriteW}, 32'd0);
        beat(1, 1, 0, 32'hDEAD_BEEF, 32'h55, 2'd0, 5'd7, 3'b010);
        step();
        chk("x7_we", {31'd0, RegWriteW}, 32'd1);
        chk("x7_rd", {27'd0, rdW}, 32'd7);
        chk("x7_data", WriteDataW, 32'h55);
        beat(0, 0, 0, 32'h0, 32'h0, 2'd0, 5'd0, 3'b000);
        step();
        chk("drain_valid", {31'd0, OutValidW}, 32'd0);

        // Backpressure fills the skid entry and holds the head.
        OutReadyW = 1'b0;
        beat(1, 1, 0, 32'h0, 32'hAAAA_0001, 2'd0, 5'd1, 3'b010);
        step();
        beat(1, 1, 0, 32'h0, 32'hBBBB_0002, 2'd0, 5'd2, 3'b010);
        step();
        beat(1, 1, 0, 32'h0, 32'hCCCC_0003, 2'd0, 5'd3, 3'b010);
        chk("full_ready", {31'd0, InReadyM}, 32'd0);
        chk("full_head", WriteDataW, 32'hAAAA_0001);
        repeat (2) step();
        chk("hold_data", WriteDataW, 32'hAAAA_0001);
        chk("hold_rd", {27'd0, rdW}, 32'd1);
        chk("hold_ready", {31'd0, InReadyM}, 32'd0);
        OutReadyW = 1'b1;
        step();
        chk("popA_head", WriteDataW, 32'hBBBB_0002);
        chk("popA_ready", {31'd0, InReadyM}, 32'd1);
        step();
        chk("popB_head", WriteDataW, 32'hCCCC_0003);
        beat(0, 0, 0, 32'h0, 32'h0, 2'd0, 5'd0, 3'b000);
        step();
        chk("popC_valid", {31'd0, OutValidW}, 32'd0);

        // Flush in state TWO with an incoming beat.
        OutReadyW = 1'b0;
        beat(1, 1, 0, 32'h0, 32'h1111_0001, 2'd0, 5'd5, 3'b010);
        step();
        beat(1, 1, 0, 32'h0, 32'h2222_0002, 2'd0, 5'd6, 3'b010);
        step();
        beat(1, 1, 0, 32'h0, 32'h3333_0003, 2'd0, 5'd9, 3'b010);
        FlushW = 1'b1;
        step();
        FlushW = 1'b0;
        beat(0, 0, 0, 32'h0, 32'h0, 2'd0, 5'd0, 3'b000);
        chk("flush_valid", {31'd0, OutValidW}, 32'd0);
        chk("flush_ready", {31'd0, InReadyM}, 32'd1);
        chk("flush_we", {31'd0, RegWriteW}, 32'd0);
        OutReadyW = 1'b1;
        repeat (2) step();
        chk("flush_stays_empty", {31'd0, OutValidW}, 32'd0);

        // Reset in state TWO clears every output register.
        OutReadyW = 1'b0;
        beat(1, 1, 1, 32'hF0F0_F0F0, 32'h0, 2'd0, 5'd11, 3'b010);
        step();
        beat(1, 1, 1, 32'h0F0F_0F0F, 32'h0, 2'd0, 5'd12, 3'b010);
        step();
        beat(0, 0, 0, 32'h0, 32'h0, 2'd0, 5'd0, 3'b000);
        chk("pre_rst_ready", {31'd0, InReadyM}, 32'd0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("mid_rst_valid", {31'd0, OutValidW}, 32'd0);
        chk("mid_rst_rd", {27'd0, rdW}, 32'd0);
        chk("mid_rst_data", WriteDataW, 32'd0);
        chk("mid_rst_f3", {29'd0, Funct3W}, 32'd0);
        chk("mid_rst_we", {31'd0, RegWriteW}, 32'd0);
        chk("mid_rst_ready", {31'd0, InReadyM}, 32'd1);

        // Single-register variant: ready follows OutReadyW combinationally.
        RegWriteM = 1'b1; MemtoRegM = 1'b1; ReadDataM = 32'h8000_7F00;
        AddrLsbM = 2'd1; rdM = 5'd13; Funct3M = 3'b000;
        InValid0 = 1'b1;
        chk("s0_empty_ready", {31'd0, InReady0}, 32'd1);
        step();
        InValid0 = 1'b0;
        chk("s0_full_ready", {31'd0, InReady0}, 32'd0);
        chk("s0_valid", {31'd0, OutValid0}, 32'd1);
        chk("s0_data", WriteData0, 32'h0000_007F);
        chk("s0_rd", {27'd0, rd0}, 32'd13);
        chk("s0_f3", {29'd0, Funct30}, 32'd0);
        chk("s0_we_held", {31'd0, RegWrite0}, 32'd0);
        OutReadyW = 1'b1;
        #1;
        chk("s0_ready_comb", {31'd0, InReady0}, 32'd1);
        chk("s0_we_pop", {31'd0, RegWrite0}, 32'd1);
        step();
        chk("s0_drained", {31'd0, OutValid0}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
